// File: rtl/ysyx_23060303_inst_mem.sv
// Instruction fetch memory: a word array preloaded through a write port, read by a
// one-outstanding valid/ready fetch port with a fixed, parameterised response latency.
module ysyx_23060303_inst_mem #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_idx,
  input  logic [31:0]           load_data,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // The request side is ready only in IDLE; the response side holds valid and data
  // stable until the consumer's ready completes the transfer.

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_inst_q, pend_inst_d;
  logic        pend_err_q, pend_err_d;
  logic [31:0] resp_inst_q, resp_inst_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]           offset;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           fetch_inst;
  logic                  accept;

  // Preload port is independent of the FSM and of reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  assign offset     = req_addr - BASE_ADDR;
  assign addr_err   = (req_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
  assign rd_idx     = offset[DEPTH_LOG2+1:2];
  // The array read sees the old word when a preload hits the same index this cycle.
  assign fetch_inst = addr_err ? NOP_INST : mem[rd_idx];

  // Reset dominates, so never advertise ready while it is asserted.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_inst_d = pend_inst_q;
    pend_err_d  = pend_err_q;
    resp_inst_d = resp_inst_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d     = S_RESP;
            resp_inst_d = fetch_inst;
            resp_err_d  = addr_err;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = CNT_INIT;
            pend_inst_d = fetch_inst;
            pend_err_d  = addr_err;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          resp_inst_d = pend_inst_q;
          resp_err_d  = pend_err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      pend_inst_q <= 32'h0;
      pend_err_q  <= 1'b0;
      resp_inst_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_inst_q <= pend_inst_d;
      pend_err_q  <= pend_err_d;
      resp_inst_q <= resp_inst_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign resp_valid  = (state_q == S_RESP);
  assign resp_inst   = resp_inst_q;
  assign resp_err    = resp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_23060303_inst_mem.sv
// Directed bench: one DUT with default parameters and a second with LATENCY=1 and a
// 16-word array, checked task by task against hand-computed values.
module tb_ysyx_23060303_inst_mem;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
  logic [31:0] req_addr, resp_inst, load_data;
  logic [9:0]  load_idx;
  logic [1:0]  dbg_state;

  logic        req_valid_1, req_ready_1, resp_valid_1, resp_ready_1, resp_err_1, load_en_1;
  logic [31:0] req_addr_1, resp_inst_1, load_data_1;
  logic [3:0]  load_idx_1;
  logic [1:0]  dbg_state_1;

  ysyx_23060303_inst_mem #(.DEPTH_LOG2(10), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .dbg_state_o(dbg_state)
  );

  ysyx_23060303_inst_mem #(.DEPTH_LOG2(4), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_inst(resp_inst_1), .resp_err(resp_err_1),
    .load_en(load_en_1), .load_idx(load_idx_1), .load_data(load_data_1), .dbg_state_o(dbg_state_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs are then driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    load_en = 1'b1; load_idx = 10'd0;    load_data = 32'h0010_0093;
    load_en_1 = 1'b1; load_idx_1 = 4'd0; load_data_1 = 32'hA000_0000;
    step();
    load_idx = 10'd3;    load_data = 32'h1111_1111;
    load_idx_1 = 4'd1;   load_data_1 = 32'hA000_0001;
    step();
    load_idx = 10'd1;    load_data = 32'h0020_0113;
    load_idx_1 = 4'd2;   load_data_1 = 32'hA000_0002;
    step();
    load_idx = 10'd1023; load_data = 32'hCAFE_F00D;
    load_idx_1 = 4'd3;   load_data_1 = 32'hA000_0003;
    step();
    load_en = 1'b0; load_en_1 = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_inst !== 32'h0) begin bad++; $display("FAIL reset_resp_inst got=%h exp=00000000", resp_inst); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++; if (resp_valid_1 !== 1'b0) begin bad++; $display("FAIL reset_resp_valid_1 got=%b exp=0", resp_valid_1); end
    total++; if (resp_inst_1 !== 32'h0) begin bad++; $display("FAIL reset_resp_inst_1 got=%h exp=00000000", resp_inst_1); end
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (req_ready_1 !== 1'b1) begin bad++; $display("FAIL reset_req_ready_1 got=%b exp=1", req_ready_1); end
  endtask

  task automatic test_preload();
    req_valid = 1'b1; req_addr = 32'h8000_0000; resp_ready = 1'b0;
    step();  // accept edge T
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL preload_early_valid got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL preload_busy_ready got=%b exp=0", req_ready); end
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL preload_wait_state got=%0d exp=1", dbg_state); end
    step();  // T+1: valid visible at T+2
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL preload_valid got=%b exp=1", resp_valid); end
    total++; if (resp_inst !== 32'h0010_0093) begin bad++; $display("FAIL preload_inst got=%h exp=00100093", resp_inst); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL preload_err got=%b exp=0", resp_err); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL preload_valid_clear got=%b exp=0", resp_valid); end
    total++; if (resp_inst !== 32'h0010_0093) begin bad++; $display("FAIL preload_inst_hold got=%h exp=00100093", resp_inst); end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_addr = 32'h8000_0004; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, resp_valid); end
      total++; if (resp_inst !== 32'h0020_0113) begin bad++; $display("FAIL bp_inst[%0d] got=%h exp=00200113", i, resp_inst); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
      step();
    end
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_last got=%b exp=1", resp_valid); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b exp=0", resp_valid); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [31:0] exp_inst [4];
    logic        exp_err [4];
    addrs[0] = 32'h8000_0002; exp_inst[0] = 32'h0000_0013; exp_err[0] = 1'b1;
    addrs[1] = 32'h8000_1000; exp_inst[1] = 32'h0000_0013; exp_err[1] = 1'b1;
    addrs[2] = 32'h7FFF_FFFC; exp_inst[2] = 32'h0000_0013; exp_err[2] = 1'b1;
    addrs[3] = 32'h8000_0FFC; exp_inst[3] = 32'hCAFE_F00D; exp_err[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = addrs[i]; resp_ready = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL err_valid[%0d] got=%b exp=1", i, resp_valid); end
      total++; if (resp_err !== exp_err[i]) begin bad++; $display("FAIL err_flag[%0d] got=%b exp=%b", i, resp_err, exp_err[i]); end
      total++; if (resp_inst !== exp_inst[i]) begin bad++; $display("FAIL err_inst[%0d] got=%h exp=%h", i, resp_inst, exp_inst[i]); end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_hazard();
    req_valid = 1'b1; req_addr = 32'h8000_000C; resp_ready = 1'b0;
    load_en = 1'b1; load_idx = 10'd3; load_data = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0; load_en = 1'b0;
    step();
    total++; if (resp_inst !== 32'h1111_1111) begin bad++; $display("FAIL hazard_old got=%h exp=11111111", resp_inst); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    load_en = 1'b1; load_idx = 10'd3; load_data = 32'h5555_5555;
    step();
    load_en = 1'b0;
    total++; if (resp_inst !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hazard_new got=%h exp=deadbeef", resp_inst); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    req_valid = 1'b1; req_addr = 32'h8000_0000; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", resp_valid); end
    total++; if (resp_inst !== 32'h0) begin bad++; $display("FAIL abort_inst got=%h exp=00000000", resp_inst); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL abort_err got=%b exp=0", resp_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_quiet[%0d] got=%b exp=0", i, resp_valid); end
    end
    req_valid = 1'b1; req_addr = 32'h8000_0004;
    step();
    req_valid = 1'b0;
    step();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL abort_new_valid got=%b exp=1", resp_valid); end
    total++; if (resp_inst !== 32'h0020_0113) begin bad++; $display("FAIL abort_new_inst got=%h exp=00200113", resp_inst); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_latency1_stream();
    resp_ready_1 = 1'b1;
    req_valid_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr_1 = 32'h8000_0000 + 32'(i * 4);
      step();
      total++; if (resp_valid_1 !== 1'b1) begin bad++; $display("FAIL lat1_valid[%0d] got=%b exp=1", i, resp_valid_1); end
      total++; if (resp_inst_1 !== (32'hA000_0000 + 32'(i))) begin bad++; $display("FAIL lat1_inst[%0d] got=%h exp=%h", i, resp_inst_1, 32'hA000_0000 + 32'(i)); end
      total++; if (req_ready_1 !== 1'b0) begin bad++; $display("FAIL lat1_busy[%0d] got=%b exp=0", i, req_ready_1); end
      step();
      total++; if (resp_valid_1 !== 1'b0) begin bad++; $display("FAIL lat1_gap[%0d] got=%b exp=0", i, resp_valid_1); end
      total++; if (req_ready_1 !== 1'b1) begin bad++; $display("FAIL lat1_ready[%0d] got=%b exp=1", i, req_ready_1); end
    end
    req_valid_1 = 1'b0;
    req_addr_1 = 32'h8000_0040;
    req_valid_1 = 1'b1;
    step();
    req_valid_1 = 1'b0;
    total++; if (resp_err_1 !== 1'b1) begin bad++; $display("FAIL lat1_range_err got=%b exp=1", resp_err_1); end
    total++; if (resp_inst_1 !== 32'h0000_0013) begin bad++; $display("FAIL lat1_range_inst got=%h exp=00000013", resp_inst_1); end
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    load_en = 1'b0; load_idx = '0; load_data = 32'h0;
    req_valid_1 = 1'b0; req_addr_1 = 32'h0; resp_ready_1 = 1'b0;
    load_en_1 = 1'b0; load_idx_1 = '0; load_data_1 = 32'h0;
    test_reset();
    test_preload();
    test_backpressure();
    test_errors();
    test_hazard();
    test_reset_abort();
    test_latency1_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060303_inst_mem.md
YSYX_23060303_INST_MEM -- requirements
Module: ysyx_23060303_inst_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words in the array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response valid; legal range is 1..15.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit, synchronous active-high reset).
REQ-005 SHALL have port req_valid (input, 1 bit): a fetch request is present.
REQ-006 SHALL have port req_ready (output, 1 bit): the block can accept a request.
REQ-007 SHALL have port req_addr (input, 32 bits): fetch byte address (pc).
REQ-008 SHALL have port resp_valid (output, 1 bit): resp_inst and resp_err are valid.
REQ-009 SHALL have port resp_ready (input, 1 bit): the consumer accepts the response.
REQ-010 SHALL have port resp_inst (output, 32 bits): fetched instruction word.
REQ-011 SHALL have port resp_err (output, 1 bit): the address was misaligned or out of range.
REQ-012 SHALL have port load_en (input, 1 bit): preload write strobe.
REQ-013 SHALL have port load_idx (input, DEPTH_LOG2 bits): preload word index.
REQ-014 SHALL have port load_data (input, 32 bits): preload word.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request at the rising edge where req_valid && req_ready; accepting latches the address, and no other request is accepted until return to IDLE.
REQ-017 SHALL, on accept, go to RESP when LATENCY==1, else go to WAIT with the down-counter loaded to LATENCY-2.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it is 0, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 SHALL, in RESP, hold resp_valid=1 and resp_inst/resp_err stable until resp_valid && resp_ready; on that edge go to IDLE, clear resp_valid and raise req_ready the next cycle (no same-cycle back-to-back; minimum 1 IDLE cycle per request).
REQ-020 SHALL compute word index = (req_addr - BASE_ADDR)[DEPTH_LOG2+1:2], using 32-bit wrap-around subtraction.
REQ-021 SHALL flag an error when req_addr[1:0]!=0 or req_addr-BASE_ADDR >= 4*2^DEPTH_LOG2; on error resp_err=1 and resp_inst=32'h0000_0013 (nop), and the array is not read.
REQ-022 SHALL sample the array word at the accept edge; a load_en write to the same index in the accept cycle SHALL NOT be visible (read-before-write), and later writes SHALL NOT alter a pending response.
REQ-023 SHALL accept load_en writes in every state, including during reset, one word per cycle.
REQ-024 SHALL leave resp_inst and resp_err at the values of the last response outside RESP.
REQ-025 SHALL have no combinational path from req_* or resp_ready to any output.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set state=IDLE, counter=0, resp_valid=0, resp_inst=32'h0, resp_err=0, with req_ready=1 from the next cycle.
REQ-027 SHALL, on reset mid-WAIT or mid-RESP, abort the transaction silently with no response.
REQ-028 SHALL NOT clear array contents on reset.

Verification
REQ-029 SHALL cover preload: word0=32'h0010_0093, LATENCY=2; request at 32'h8000_0000 accepted at edge T -> resp_valid=1 at T+2, resp_inst=32'h0010_0093, resp_err=0.
REQ-030 SHALL cover backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_inst stable for all 5 cycles and req_ready=0; after handshake -> req_ready=1 one cycle later.
REQ-031 SHALL cover errors: req_addr=32'h8000_0002 -> resp_err=1, resp_inst=32'h0000_0013; req_addr=32'h8000_1000 with DEPTH_LOG2=10 -> resp_err=1; req_addr=32'h7FFF_FFFC -> resp_err=1.
REQ-032 SHALL cover the same-cycle hazard: load_en to index 3 with 32'hDEAD_BEEF in the accept cycle of 32'h8000_000C (old 32'h1111_1111) -> resp 32'h1111_1111; the next request to the same address -> 32'hDEAD_BEEF.
REQ-033 SHALL cover reset abort: rst pulsed during WAIT -> no resp_valid, outputs zero, a new request completes normally.
REQ-034 SHALL cover LATENCY=1: resp_valid one cycle after accept; streaming 4 requests with resp_ready=1 -> one response every 2 cycles, in order.
